conv_scan_ctrl: RTL
===================

// Module: conv_scan_ctrl
// PURPOSE
//  Sequences the 3x3 convolution datapath (row RAM, MAC chain, clamp) over one image frame.
//  Raster-scans output rows 1..IMG_H-2, issuing three row read addresses per column.
//  Carries a coordinate tag through a PIPE_LAT-deep shadow pipeline so each clamped result
//  is marked valid with its (x,y) and linear output index. Start/done handshake; stall freezes the whole path.
// PARAMETERS
//  IMG_W     128  image width in pixels (>=3)
//  IMG_H     128  image height in pixels (>=3)
//  PIPE_LAT  4    cycles from a rd_en cycle to the clamped result of that column at datapath output
//  COL_W     7    width of column/x counters (2**COL_W >= IMG_W)
//  ROW_W     7    width of row/y counters (2**ROW_W >= IMG_H)
//  ADDR_W    14   read address width (2**ADDR_W >= IMG_W*IMG_H)
//  IDX_W     14   output index width (2**IDX_W >= (IMG_W-2)*(IMG_H-2))
// PORTS
//  clock     in   1       clock, all state on rising edge
//  reset     in   1       synchronous, active-high
//  start     in   1       begin a frame; sampled only in IDLE
//  stall     in   1       downstream not ready; freezes scan, tags and datapath
//  rd_en     out  1       row RAM read strobe
//  rd_addr0  out  ADDR_W  (row-1)*IMG_W+col, top window row
//  rd_addr1  out  ADDR_W  row*IMG_W+col, centre row
//  rd_addr2  out  ADDR_W  (row+1)*IMG_W+col, bottom row
//  pipe_en   out  1       clock enable for RAM and MAC cells
//  out_valid out  1       datapath output is a valid convolved pixel this cycle
//  out_x     out  COL_W   centre column of the valid pixel (1..IMG_W-2)
//  out_y     out  ROW_W   centre row of the valid pixel (1..IMG_H-2)
//  out_idx   out  IDX_W   linear output index, 0..(IMG_W-2)*(IMG_H-2)-1
//  busy      out  1       high in SCAN, DRAIN, DONE
//  done      out  1       one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: state IDLE; every output 0; row=1, col=0; tag pipe cleared; out_idx=0.
//  FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 -> SCAN next cycle with row=1, col=0, out_idx=0. Stall ignored.
//   SCAN: each stall=0 cycle: rd_en=1, addresses from current (row,col), col++.
//         col==IMG_W-1 -> col=0, row++. Last column of row IMG_H-2 -> DRAIN.
//         Exactly IMG_W*(IMG_H-2) rd_en cycles per frame.
//   DRAIN: rd_en=0; counts PIPE_LAT non-stalled cycles, then DONE.
//   DONE: done=1, busy=1 for one cycle (stall ignored); -> IDLE. start here ignored.
//  start while busy is ignored; start held high runs back-to-back frames, one IDLE cycle apart.
//  Tag pipe: each rd_en cycle pushes {v=(col>=2), x=col-1, y=row}. Tag appears at the output
//   exactly PIPE_LAT non-stalled cycles later. out_valid = tag.v & ~stall.
//   out_idx increments after each out_valid cycle.
//  Row wrap: cols 0,1 of each row push v=0. Stale previous-row columns in the MAC window never
//   produce out_valid.
//  stall=1 (SCAN/DRAIN): rd_en=0, pipe_en=0, out_valid=0. row, col, addresses, tags, counters
//   and FSM all held. Resumes on the first stall=0 cycle with no skipped or duplicated column.
//  pipe_en = (SCAN|DRAIN) & ~stall. It is 0 in IDLE and DONE.
//  rd_addr* hold their last value when rd_en=0. Addresses use incrementing base registers (no multiplier).
//  Reset mid-frame: IDLE next cycle, no done, out_valid=0. The next frame starts from address 0.
// TESTING  (IMG_W=5, IMG_H=4, PIPE_LAT=4; cycle 0 = start sampled in IDLE)
//  T1 reset held 3 cycles -> all outputs 0, busy=0; stall/start toggling while reset=1 has no effect.
//  T2 start pulse, no stall -> rd_en cycles 1..10; cycle1 addrs 0/5/10; cycle10 addrs 9/14/19;
//     out_valid cycles 7,8,9 and 12,13,14; first (x1,y1,idx0), last (x3,y2,idx5);
//     done=1 at cycle 15 only; busy cycles 1..15.
//  T3 row wrap -> out_valid low cycles 10,11; out_x 3->1 and out_y 1->2 across the gap.
//  T4 stall=1 cycles 4..6 -> rd_en/pipe_en/out_valid low; addrs frozen at 3/8/13;
//     whole timeline +3; done at cycle 18; 6 valid pixels, idx 0..5 in order.
//  T5 start held high 40 cycles -> second frame rd_en resumes cycle 17 at addrs 0/5/10;
//     start pulses during busy have no effect.
//  T6 reset at cycle 9 -> cycle 10 IDLE, no done, out_valid=0; new start gives full T2 sequence.

Source files
------------

// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 convolution path: issues three row reads per column and
// tags each clamped result PIPE_LAT enabled cycles later; stall freezes scan, tags and datapath.
module conv_scan_ctrl #(
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int PIPE_LAT = 4,
    parameter int COL_W    = 7,
    parameter int ROW_W    = 7,
    parameter int ADDR_W   = 14,
    parameter int IDX_W    = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic              pipe_en,
    output logic              out_valid,
    output logic [COL_W-1:0]  out_x,
    output logic [ROW_W-1:0]  out_y,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             v;
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
    } tag_t;

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic [IDX_W-1:0]  r_idx;
    tag_t              r_tag [PIPE_LAT];

    logic w_rd_en;
    logic w_pipe_en;
    logic w_out_valid;
    logic w_last_col;
    tag_t w_push;

    assign w_rd_en     = (r_state == S_SCAN) & ~stall;
    assign w_pipe_en   = ((r_state == S_SCAN) | (r_state == S_DRAIN)) & ~stall;
    assign w_out_valid = r_tag[PIPE_LAT-1].v & w_pipe_en;
    assign w_last_col  = (r_col == COL_LAST);

    // Columns 0 and 1 only prime the window, so their results are never marked valid.
    assign w_push.v = w_rd_en & (r_col >= COL_W'(2));
    assign w_push.x = r_col - COL_W'(1);
    assign w_push.y = r_row;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= ROW_W'(1);
            r_col       <= '0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_row   <= ROW_W'(1);
                        r_col   <= '0;
                        r_addr0 <= '0;
                        r_addr1 <= ROW_STEP;
                        r_addr2 <= ROW_STEP + ROW_STEP;
                    end
                end
                S_SCAN: begin
                    if (!stall) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state     <= S_DRAIN;
                                r_drain_cnt <= '0;
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        // Raster order makes every window row a plain linear counter;
                        // the final read's address is kept on the outputs.
                        if (!(w_last_col && r_row == ROW_LAST)) begin
                            r_addr0 <= r_addr0 + ADDR_W'(1);
                            r_addr1 <= r_addr1 + ADDR_W'(1);
                            r_addr2 <= r_addr2 + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (r_drain_cnt == CNT_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (w_pipe_en) begin
            r_tag[0] <= w_push;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_idx <= '0;
        end else if (w_out_valid) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign rd_en     = w_rd_en;
    assign rd_addr0  = r_addr0;
    assign rd_addr1  = r_addr1;
    assign rd_addr2  = r_addr2;
    assign pipe_en   = w_pipe_en;
    assign out_valid = w_out_valid;
    assign out_x     = r_tag[PIPE_LAT-1].x;
    assign out_y     = r_tag[PIPE_LAT-1].y;
    assign out_idx   = r_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
